// File: rtl/box_cmd_sequencer.sv
// rtl/box_cmd_sequencer.sv - queued box/clear command sequencer driving a box drawer
module box_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int HOLD    = 2,
   parameter int TIMEOUT = 20000
) (
   input  logic                     iClock,
   input  logic                     iResetn,
   input  logic                     iCmdValid,
   input  logic                     iCmdClear,
   input  logic [6:0]               iCmdX,
   input  logic [6:0]               iCmdY,
   input  logic [2:0]               iCmdColour,
   output logic                     oCmdReady,
   output logic                     oLoadX,
   output logic                     oPlotBox,
   output logic                     oBlack,
   output logic [6:0]               oXY_Coord,
   output logic [2:0]               oColour,
   input  logic                     iDrawDone,
   output logic                     oBusy,
   output logic [$clog2(DEPTH):0]   oCount,
   output logic                     oError
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE, X_HI, X_LO, Y_HI, Y_LO, BLK_HI, BLK_LO, WAIT_DONE
   } state_t;

   // entry layout: {clear, x[6:0], y[6:0], colour[2:0]}
   logic [17:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop;
   logic [17:0]   head;

   state_t        state, state_n;
   logic [2:0]    hold_cnt, hold_n;
   logic [14:0]   tmo_cnt, tmo_n;
   logic [17:0]   cmd_q, cmd_n;
   logic          err_n;
   logic          load_n, plot_n, black_n;
   logic [6:0]    xy_n;
   logic [2:0]    col_n;

   assign oCmdReady = (count != CW'(DEPTH));
   assign push      = iCmdValid && oCmdReady;
   assign head      = mem[rd_ptr];
   assign oCount    = count;
   assign oBusy     = (state != IDLE);

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge iClock) begin
      if (push) mem[wr_ptr] <= {iCmdClear, iCmdX, iCmdY, iCmdColour};
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // state, counters, command register and registered drawer outputs
   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         tmo_cnt   <= '0;
         cmd_q     <= '0;
         oError    <= 1'b0;
         oLoadX    <= 1'b0;
         oPlotBox  <= 1'b0;
         oBlack    <= 1'b0;
         oXY_Coord <= '0;
         oColour   <= '0;
      end else begin
         state     <= state_n;
         hold_cnt  <= hold_n;
         tmo_cnt   <= tmo_n;
         cmd_q     <= cmd_n;
         oError    <= err_n;
         oLoadX    <= load_n;
         oPlotBox  <= plot_n;
         oBlack    <= black_n;
         oXY_Coord <= xy_n;
         oColour   <= col_n;
      end
   end

   // next state, and outputs decoded from the next state so they register with it
   always_comb begin
      state_n = state;
      hold_n  = '0;
      tmo_n   = '0;
      cmd_n   = cmd_q;
      err_n   = oError;
      pop     = 1'b0;
      load_n  = 1'b0;
      plot_n  = 1'b0;
      black_n = 1'b0;
      xy_n    = '0;
      col_n   = '0;

      case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               cmd_n   = head;
               state_n = head[17] ? BLK_HI : X_HI;
            end
         end
         X_HI: begin
            if (hold_cnt == 3'(HOLD - 1)) state_n = X_LO;
            else                          hold_n  = hold_cnt + 1'b1;
         end
         X_LO:   state_n = Y_HI;
         Y_HI: begin
            if (hold_cnt == 3'(HOLD - 1)) state_n = Y_LO;
            else                          hold_n  = hold_cnt + 1'b1;
         end
         Y_LO:   state_n = WAIT_DONE;
         BLK_HI: begin
            if (hold_cnt == 3'(HOLD - 1)) state_n = BLK_LO;
            else                          hold_n  = hold_cnt + 1'b1;
         end
         BLK_LO: state_n = WAIT_DONE;
         WAIT_DONE: begin
            // done wins over a timeout landing on the same cycle
            if (iDrawDone) begin
               state_n = IDLE;
            end else if (tmo_cnt == 15'(TIMEOUT - 1)) begin
               state_n = IDLE;
               err_n   = 1'b1;
            end else begin
               tmo_n = tmo_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      case (state_n)
         X_HI: begin
            load_n = 1'b1;
            xy_n   = cmd_n[16:10];
         end
         X_LO:   xy_n = cmd_n[16:10];
         Y_HI: begin
            plot_n = 1'b1;
            xy_n   = cmd_n[9:3];
            col_n  = cmd_n[2:0];
         end
         Y_LO: begin
            xy_n  = cmd_n[9:3];
            col_n = cmd_n[2:0];
         end
         BLK_HI: black_n = 1'b1;
         default: ;
      endcase
   end

endmodule
